// File: rtl/ringbuf_pkg.sv
`default_nettype none
// =============================================================================
// ringbuf_pkg - shared word width, event sizing helper and FSM state encodings
// Rev 1.0
// =============================================================================
package ringbuf_pkg;

  localparam int WORD_W = 12;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_STORE = 2'd1,
    W_DROP  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_t;

  function automatic int evt_words(input int nchan, input int nsamp);
    return nchan * nsamp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ringbuf_evt_wr_ctrl_if.sv
`default_nettype none
// =============================================================================
// ringbuf_evt_wr_ctrl_if - sample input, readout handshake and status signals
// Rev 1.0
// =============================================================================
interface ringbuf_evt_wr_ctrl_if
  import ringbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11
);

  logic                  wren;
  logic [WORD_W-1:0]     din;
  logic [WORD_W-1:0]     dout;
  logic                  dout_valid;
  logic                  dout_rdy;
  logic                  dout_last;
  logic [DEPTH_LOG2:0]   evt_cnt;
  logic [15:0]           drop_cnt;
  logic                  ovfl;
  logic                  par_err;

  modport master (
    output wren, din, dout_rdy,
    input  dout, dout_valid, dout_last, evt_cnt, drop_cnt, ovfl, par_err
  );

  modport slave (
    input  wren, din, dout_rdy,
    output dout, dout_valid, dout_last, evt_cnt, drop_cnt, ovfl, par_err
  );

endinterface
`default_nettype wire

// File: rtl/ringbuf_dpram.sv
`default_nettype none
// =============================================================================
// ringbuf_dpram - simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// =============================================================================
module ringbuf_dpram #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  wire           clk,
  input  wire           we,
  input  wire  [AW-1:0] waddr,
  input  wire  [DW-1:0] wdata,
  input  wire           re,
  input  wire  [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/ringbuf_evt_wr_ctrl.sv
`default_nettype none
// =============================================================================
// ringbuf_evt_wr_ctrl - packs whole sample events into a circular buffer and
// streams complete events out; optional RINGBUF_PARITY_EN adds word parity.
// Rev 1.0
// =============================================================================
module ringbuf_evt_wr_ctrl
  import ringbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11,
  parameter int NCHAN      = 16,
  parameter int NSAMP      = 8
) (
  input wire clk,
  input wire rst_n,
  ringbuf_evt_wr_ctrl_if.slave bus
);

  localparam int EVT_WORDS = evt_words(NCHAN, NSAMP);
  localparam int WCW       = $clog2(EVT_WORDS);
  localparam int PW        = DEPTH_LOG2 + 1;
`ifdef RINGBUF_PARITY_EN
  localparam int DW        = WORD_W + 1;
`else
  localparam int DW        = WORD_W;
`endif
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(EVT_WORDS - 1);
  localparam logic [WCW:0]   EVT_WORDS_C = (WCW+1)'(EVT_WORDS);
  localparam logic [PW-1:0]  FIT_MAX     = PW'((1 << DEPTH_LOG2) - EVT_WORDS);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [PW-1:0]         wr_ptr, rd_ptr, occupancy, evt_cnt;
  logic [DEPTH_LOG2-1:0] fetch_ptr;
  logic [WCW-1:0]        wr_word, rd_word;
  logic [WCW:0]          fetch_cnt;
  logic [15:0]           drop_cnt;
  logic                  ovfl, fits, wr_last;
  logic                  mem_we, drop_start, evt_done;
  logic                  issue, rvalid, pop, last_acc, dout_valid;
  logic [DW-1:0]         wdata, rdata, skid0, skid1;
  logic [1:0]            skid_cnt;

  // Free space is judged against the consumed read pointer, not the fetch pointer.
  assign occupancy = wr_ptr - rd_ptr;
  assign fits      = (occupancy <= FIT_MAX);
  assign wr_last   = (wr_word == LAST_WORD);

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:          if (bus.wren) wr_state_nxt = fits ? W_STORE : W_DROP;
      W_STORE, W_DROP: if (bus.wren && wr_last) wr_state_nxt = W_IDLE;
      default:         wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    mem_we     = 1'b0;
    drop_start = 1'b0;
    evt_done   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        mem_we     = bus.wren && fits;
        drop_start = bus.wren && !fits;
      end
      W_STORE: begin
        mem_we   = bus.wren;
        evt_done = bus.wren && wr_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_word  <= '0;
      drop_cnt <= '0;
      ovfl     <= 1'b0;
    end else begin
      ovfl <= drop_start;
      if (mem_we)    wr_ptr  <= wr_ptr + 1'b1;
      if (bus.wren)  wr_word <= wr_last ? '0 : wr_word + 1'b1;
      if (drop_start && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef RINGBUF_PARITY_EN
  assign wdata = {^bus.din, bus.din};
`else
  assign wdata = bus.din;
`endif

  ringbuf_dpram #(.AW(DEPTH_LOG2), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wdata),
    .re    (issue),
    .raddr (fetch_ptr),
    .rdata (rdata)
  );

  // ---------------- read FSM ----------------
  assign dout_valid = (skid_cnt != 2'd0);
  assign pop        = dout_valid && bus.dout_rdy;
  assign last_acc   = pop && (rd_word == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:   if (evt_cnt != '0) rd_state_nxt = R_FETCH;
      R_FETCH:  rd_state_nxt = R_STREAM;
      R_STREAM: if (last_acc) rd_state_nxt = (evt_cnt > PW'(1)) ? R_FETCH : R_IDLE;
      default:  rd_state_nxt = R_IDLE;
    endcase
  end

  // A read is issued only if the skid plus the word in flight cannot overflow.
  always_comb begin
    issue = 1'b0;
    if ((rd_state == R_FETCH || rd_state == R_STREAM) && fetch_cnt < EVT_WORDS_C)
      issue = ((3'(skid_cnt) + 3'(rvalid)) < 3'd2) || pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid    <= 1'b0;
      fetch_ptr <= '0;
      fetch_cnt <= '0;
      rd_ptr    <= '0;
      rd_word   <= '0;
      evt_cnt   <= '0;
    end else begin
      rvalid <= issue;
      if (issue) fetch_ptr <= fetch_ptr + 1'b1;
      if (last_acc)   fetch_cnt <= '0;
      else if (issue) fetch_cnt <= fetch_cnt + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_word <= (rd_word == LAST_WORD) ? '0 : rd_word + 1'b1;
      end
      case ({evt_done, last_acc})
        2'b10:   evt_cnt <= evt_cnt + 1'b1;
        2'b01:   evt_cnt <= evt_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Two-entry output skid; skid0 is always the word presented on dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= 2'd0;
    end else begin
      case ({rvalid, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= rdata;
          else                  skid1 <= rdata;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= rdata;
          end else begin
            skid0 <= skid1;
            skid1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout       = skid0[WORD_W-1:0];
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last  = dout_valid && (rd_word == LAST_WORD);
  assign bus.evt_cnt    = evt_cnt;
  assign bus.drop_cnt   = drop_cnt;
  assign bus.ovfl       = ovfl;

`ifdef RINGBUF_PARITY_EN
  assign bus.par_err = pop && (^skid0);
`else
  assign bus.par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ringbuf_evt_wr_ctrl.sv
`default_nettype none
// =============================================================================
// tb_ringbuf_evt_wr_ctrl - randomized and directed stimulus against an event-level model
// Rev 1.0
// =============================================================================
module tb_ringbuf_evt_wr_ctrl;

  localparam int DEPTH_LOG2 = 11;
  localparam int NCHAN      = 16;
  localparam int NSAMP      = 8;
  localparam int EW         = NCHAN * NSAMP;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ringbuf_evt_wr_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  ringbuf_evt_wr_ctrl #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NCHAN      (NCHAN),
    .NSAMP      (NSAMP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Event-level reference model
  logic [11:0] exp_q[$];
  int  m_stored, m_acc, m_wword, m_rword, m_evt, m_drop, ovfl_seen, coinc;
  bit  m_dropping, m_ovfl, prev_hold;
  logic [11:0] prev_dout;

  task automatic model_reset();
    exp_q.delete();
    m_stored = 0; m_acc = 0; m_wword = 0; m_rword = 0;
    m_evt = 0; m_drop = 0; m_dropping = 0; m_ovfl = 0;
    prev_hold = 0; prev_dout = '0;
  endtask

  task automatic step(input bit w, input logic [11:0] d, input bit r);
    bit pop, done, last;
    done = 0;
    last = 0;
    check_val("evt_cnt",  bus.evt_cnt,  m_evt);
    check_val("drop_cnt", bus.drop_cnt, m_drop);
    check_val("ovfl",     bus.ovfl,     m_ovfl);
    check_val("par_err",  bus.par_err,  0);
    if (prev_hold) begin
      check_val("hold_valid", bus.dout_valid, 1);
      check_val("hold_dout",  bus.dout,       prev_dout);
    end
    if (bus.dout_valid) begin
      check_val("valid_has_evt", m_evt > 0, 1);
      if (exp_q.size() == 0) check_val("valid_no_data", bus.dout_valid, 0);
      else                   check_val("dout", bus.dout, exp_q[0]);
      check_val("dout_last", bus.dout_last, m_rword == EW - 1);
    end else begin
      check_val("dout_last_idle", bus.dout_last, 0);
    end
    if (bus.ovfl) ovfl_seen++;

    bus.wren     = w;
    bus.din      = d;
    bus.dout_rdy = r;
    pop = bus.dout_valid && r;

    m_ovfl = 0;
    if (w) begin
      if (m_wword == 0) begin
        m_dropping = !((m_stored - m_acc) <= DEPTH - EW);
        if (m_dropping) begin
          m_ovfl = 1;
          if (m_drop < 16'hFFFF) m_drop++;
        end
      end
      if (!m_dropping) begin
        exp_q.push_back(d);
        m_stored++;
      end
      if (m_wword == EW - 1) begin
        done    = !m_dropping;
        m_wword = 0;
      end else begin
        m_wword++;
      end
    end
    if (pop) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_acc++;
      last    = (m_rword == EW - 1);
      m_rword = last ? 0 : m_rword + 1;
    end
    m_evt = m_evt + int'(done) - int'(last);
    if (done && last) coinc++;
    prev_hold = bus.dout_valid && !r;
    prev_dout = bus.dout;
    @(negedge clk);
  endtask

  task automatic write_event(input int base, input bit rnd, input bit r);
    for (int i = 0; i < EW; i++)
      step(1'b1, rnd ? 12'($urandom_range(0, 4095)) : 12'(base + i), r);
  endtask

  task automatic drain(input bit toggle);
    int cyc;
    cyc = 0;
    while ((m_evt != 0 || bus.dout_valid) && cyc < 6000) begin
      step(1'b0, 12'd0, toggle ? bit'(cyc % 2) : 1'b1);
      cyc++;
    end
    check_val("drain_done", (m_evt == 0) && !bus.dout_valid, 1);
    check_val("drain_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus.wren = 0; bus.din = '0; bus.dout_rdy = 0;
    ovfl_seen = 0; coinc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_dout_valid", bus.dout_valid, 0);
    check_val("rst_evt_cnt",    bus.evt_cnt,    0);
    check_val("rst_drop_cnt",   bus.drop_cnt,   0);
    check_val("rst_dout",       bus.dout,       0);
    rst_n = 1;

    // single event 0..127
    write_event(0, 1'b0, 1'b1);
    drain(1'b0);

    // fill 16 events without reading, 17th must be dropped
    for (int e = 0; e < 17; e++) write_event(e * 7, 1'b0, 1'b0);
    repeat (4) step(1'b0, 12'd0, 1'b0);
    check_val("full_evt_cnt",  bus.evt_cnt,  16);
    check_val("full_drop_cnt", bus.drop_cnt, 1);
    check_val("full_ovfl_pulses", ovfl_seen, 1);
    drain(1'b0);

    // backpressure toggling every cycle
    write_event(0, 1'b1, 1'b0);
    drain(1'b1);

    // coincidence: last read of event A on the same edge event B completes
    write_event(0, 1'b1, 1'b0);
    repeat (8) step(1'b0, 12'd0, 1'b0);
    write_event(0, 1'b1, 1'b1);
    check_val("coincidence_seen", coinc > 0, 1);
    drain(1'b0);

    // randomized traffic, enough words to wrap the pointers repeatedly
    for (int e = 0; e < 45; e++) begin
      for (int i = 0; i < EW; i++) begin
        while ($urandom_range(0, 3) == 0)
          step(1'b0, 12'($urandom_range(0, 4095)), $urandom_range(0, 99) < 70);
        step(1'b1, 12'($urandom_range(0, 4095)), $urandom_range(0, 99) < 70);
      end
    end
    drain(1'b0);

    // reset in the middle of an event with a complete event pending
    write_event(0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
    rst_n = 0;
    #1;
    check_val("arst_dout_valid", bus.dout_valid, 0);
    check_val("arst_dout",       bus.dout,       0);
    check_val("arst_dout_last",  bus.dout_last,  0);
    check_val("arst_evt_cnt",    bus.evt_cnt,    0);
    check_val("arst_drop_cnt",   bus.drop_cnt,   0);
    check_val("arst_ovfl",       bus.ovfl,       0);
    bus.wren = 0; bus.dout_rdy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    write_event(100, 1'b0, 1'b1);
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
